// File: rtl/dual_issue_ctrl.sv
// Two-lane decode/issue stage: decodes a fetched pair, detects intra-pair hazards and issues the
// pair together or split over two cycles through a single registered valid/ready output stage.
module dual_issue_ctrl #(
    parameter int unsigned ALUOP_W   = 6,
    parameter int unsigned MEM_PORTS = 1,
    parameter int unsigned BR_LANE1  = 0,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [31:0]            in_instr0_i,
    input  logic [31:0]            in_instr1_i,
    input  logic [31:0]            in_pc_i,
    output logic [1:0]             out_valid_o,
    input  logic                   out_ready_i,
    output logic [63:0]            out_pc_o,
    output logic [63:0]            out_instr_o,
    output logic [3:0]             regdst_o,
    output logic [3:0]             jmp_o,
    output logic [3:0]             alusrc1_o,
    output logic [1:0]             datac_o,
    output logic [1:0]             regwrite_o,
    output logic [1:0]             alusrc_o,
    output logic [1:0]             branch_o,
    output logic [1:0]             bne_o,
    output logic [1:0]             memread_o,
    output logic [1:0]             memwrite_o,
    output logic [1:0]             memtoreg_o,
    output logic [2*ALUOP_W-1:0]   aluop_o,
    output logic [CNT_W-1:0]       split_cnt_o
);

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpJal   = 6'h03;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpBne   = 6'h05;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpAddiu = 6'h09;
    localparam logic [5:0] OpSlti  = 6'h0A;
    localparam logic [5:0] OpSltiu = 6'h0B;
    localparam logic [5:0] OpAndi  = 6'h0C;
    localparam logic [5:0] OpOri   = 6'h0D;
    localparam logic [5:0] OpXori  = 6'h0E;
    localparam logic [5:0] OpLui   = 6'h0F;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;

    localparam logic [5:0] FnSll  = 6'h00;
    localparam logic [5:0] FnSrl  = 6'h02;
    localparam logic [5:0] FnSllv = 6'h04;
    localparam logic [5:0] FnSrlv = 6'h06;
    localparam logic [5:0] FnJr   = 6'h08;
    localparam logic [5:0] FnJalr = 6'h09;
    localparam logic [5:0] FnAdd  = 6'h20;
    localparam logic [5:0] FnAddu = 6'h21;
    localparam logic [5:0] FnSub  = 6'h22;
    localparam logic [5:0] FnAnd  = 6'h24;
    localparam logic [5:0] FnOr   = 6'h25;
    localparam logic [5:0] FnXor  = 6'h26;
    localparam logic [5:0] FnSlt  = 6'h2A;
    localparam logic [5:0] FnSltu = 6'h2B;

    typedef struct packed {
        logic [1:0]         regdst;
        logic [1:0]         jmp;
        logic [1:0]         alusrc1;
        logic               datac;
        logic               regwrite;
        logic               alusrc;
        logic               branch;
        logic               bne;
        logic               memread;
        logic               memwrite;
        logic               memtoreg;
        logic [ALUOP_W-1:0] aluop;
    } ctrl_t;

    typedef enum logic {StPair, StSecond} state_e;

    function automatic ctrl_t decode(input logic [31:0] ins);
        ctrl_t c;
        c = '0;
        case (ins[31:26])
            OpRtype: begin
                case (ins[5:0])
                    FnJr: c.jmp = 2'b10;
                    FnJalr: begin
                        c.jmp      = 2'b10;
                        c.regdst   = 2'b10;
                        c.datac    = 1'b1;
                        c.regwrite = 1'b1;
                    end
                    default: begin
                        c.regdst   = 2'b01;
                        c.regwrite = 1'b1;
                        c.aluop    = ALUOP_W'(ins[5:0]);
                        // Shift-by-shamt reuses the variable-shift ALU op with shamt as source 1
                        if (ins[5:0] == FnSll) begin
                            c.aluop   = ALUOP_W'(FnSllv);
                            c.alusrc1 = 2'b01;
                        end else if (ins[5:0] == FnSrl) begin
                            c.aluop   = ALUOP_W'(FnSrlv);
                            c.alusrc1 = 2'b01;
                        end
                    end
                endcase
            end
            OpAddi:  begin c.regwrite = 1'b1; c.alusrc = 1'b1; c.aluop = ALUOP_W'(FnAdd);  end
            OpAddiu: begin c.regwrite = 1'b1; c.alusrc = 1'b1; c.aluop = ALUOP_W'(FnAddu); end
            OpAndi:  begin c.regwrite = 1'b1; c.alusrc = 1'b1; c.aluop = ALUOP_W'(FnAnd);  end
            OpOri:   begin c.regwrite = 1'b1; c.alusrc = 1'b1; c.aluop = ALUOP_W'(FnOr);   end
            OpXori:  begin c.regwrite = 1'b1; c.alusrc = 1'b1; c.aluop = ALUOP_W'(FnXor);  end
            OpSlti:  begin c.regwrite = 1'b1; c.alusrc = 1'b1; c.aluop = ALUOP_W'(FnSlt);  end
            OpSltiu: begin c.regwrite = 1'b1; c.alusrc = 1'b1; c.aluop = ALUOP_W'(FnSltu); end
            OpLui: begin
                c.regwrite = 1'b1;
                c.alusrc   = 1'b1;
                c.alusrc1  = 2'b10;
                c.aluop    = ALUOP_W'(FnSllv);
            end
            OpLw: begin
                c.regwrite = 1'b1;
                c.alusrc   = 1'b1;
                c.memread  = 1'b1;
                c.memtoreg = 1'b1;
                c.aluop    = ALUOP_W'(FnAdd);
            end
            OpSw: begin
                c.alusrc   = 1'b1;
                c.memwrite = 1'b1;
                c.aluop    = ALUOP_W'(FnAdd);
            end
            OpBeq: begin c.branch = 1'b1; c.aluop = ALUOP_W'(FnSub); end
            OpBne: begin c.branch = 1'b1; c.bne = 1'b1; c.aluop = ALUOP_W'(FnSub); end
            OpJ:   c.jmp = 2'b01;
            OpJal: begin
                c.jmp      = 2'b01;
                c.regdst   = 2'b10;
                c.datac    = 1'b1;
                c.regwrite = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // Register written by an instruction; 0 means no architectural write
    function automatic logic [4:0] dest_of(input logic [31:0] ins, input ctrl_t c);
        logic [4:0] d;
        if (c.regdst == 2'b01)      d = ins[15:11];
        else if (c.regdst == 2'b10) d = 5'd31;
        else                        d = ins[20:16];
        return c.regwrite ? d : 5'd0;
    endfunction

    function automatic logic reads_rs(input logic [31:0] ins);
        logic [5:0] op;
        logic       shamt_shift;
        op          = ins[31:26];
        shamt_shift = (op == OpRtype) && ((ins[5:0] == FnSll) || (ins[5:0] == FnSrl));
        return !((op == OpJ) || (op == OpJal) || (op == OpLui) || shamt_shift);
    endfunction

    function automatic logic reads_rt(input logic [31:0] ins);
        logic [5:0] op;
        op = ins[31:26];
        return (op == OpRtype) || (op == OpBeq) || (op == OpBne) || (op == OpSw);
    endfunction

    state_e           state_q, state_d;
    logic [1:0]       out_valid_q, out_valid_d;
    logic [63:0]      out_instr_q, out_instr_d;
    logic [63:0]      out_pc_q, out_pc_d;
    logic [31:0]      hold_instr_q, hold_instr_d;
    logic [31:0]      hold_pc_q, hold_pc_d;
    logic [CNT_W-1:0] split_cnt_q, split_cnt_d;

    ctrl_t      in_dec0, in_dec1, out_dec0, out_dec1;
    logic [4:0] dest0, dest1;
    logic       raw_hzd, waw_hzd, mem_hzd, ctl_hzd, split;
    logic       advance, accept;

    // Intra-pair hazard detection on the incoming fetch pair
    always_comb begin
        in_dec0 = decode(in_instr0_i);
        in_dec1 = decode(in_instr1_i);
        dest0   = dest_of(in_instr0_i, in_dec0);
        dest1   = dest_of(in_instr1_i, in_dec1);
        raw_hzd = (dest0 != 5'd0) &&
                  ((reads_rs(in_instr1_i) && (in_instr1_i[25:21] == dest0)) ||
                   (reads_rt(in_instr1_i) && (in_instr1_i[20:16] == dest0)));
        waw_hzd = (dest0 != 5'd0) && (dest1 == dest0);
        mem_hzd = (MEM_PORTS == 1) && (in_dec0.memread || in_dec0.memwrite) &&
                  (in_dec1.memread || in_dec1.memwrite);
        ctl_hzd = in_dec0.branch || (in_dec0.jmp != 2'b00) ||
                  ((BR_LANE1 == 0) && (in_dec1.branch || (in_dec1.jmp != 2'b00)));
        split   = raw_hzd || waw_hzd || mem_hzd || ctl_hzd;
    end

    // Issue FSM and output-stage next state; flush overrides everything
    always_comb begin
        advance      = out_ready_i || (out_valid_q == 2'b00);
        in_ready_o   = rst_ni && !flush_i && (state_q == StPair) && advance;
        accept       = in_valid_i && in_ready_o;
        state_d      = state_q;
        out_valid_d  = out_valid_q;
        out_instr_d  = out_instr_q;
        out_pc_d     = out_pc_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;
        split_cnt_d  = split_cnt_q;
        if (flush_i) begin
            state_d      = StPair;
            out_valid_d  = 2'b00;
            out_instr_d  = '0;
            out_pc_d     = '0;
            hold_instr_d = '0;
            hold_pc_d    = '0;
        end else if (advance) begin
            case (state_q)
                StPair: begin
                    if (accept && split) begin
                        out_valid_d  = 2'b01;
                        out_instr_d  = {32'd0, in_instr0_i};
                        out_pc_d     = {32'd0, in_pc_i};
                        hold_instr_d = in_instr1_i;
                        hold_pc_d    = in_pc_i + 32'd4;
                        state_d      = StSecond;
                        if (split_cnt_q != {CNT_W{1'b1}}) begin
                            split_cnt_d = split_cnt_q + CNT_W'(1);
                        end
                    end else if (accept) begin
                        out_valid_d = 2'b11;
                        out_instr_d = {in_instr1_i, in_instr0_i};
                        out_pc_d    = {in_pc_i + 32'd4, in_pc_i};
                    end else begin
                        out_valid_d = 2'b00;
                        out_instr_d = '0;
                        out_pc_d    = '0;
                    end
                end
                StSecond: begin
                    out_valid_d  = 2'b01;
                    out_instr_d  = {32'd0, hold_instr_q};
                    out_pc_d     = {32'd0, hold_pc_q};
                    hold_instr_d = '0;
                    hold_pc_d    = '0;
                    state_d      = StPair;
                end
                default: state_d = StPair;
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StPair;
            out_valid_q  <= 2'b00;
            out_instr_q  <= '0;
            out_pc_q     <= '0;
            hold_instr_q <= '0;
            hold_pc_q    <= '0;
            split_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            out_valid_q  <= out_valid_d;
            out_instr_q  <= out_instr_d;
            out_pc_q     <= out_pc_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
            split_cnt_q  <= split_cnt_d;
        end
    end

    // Decode the registered instructions; a lane that is not valid drives all-zero controls
    always_comb begin
        out_dec0 = out_valid_q[0] ? decode(out_instr_q[31:0]) : '0;
        out_dec1 = out_valid_q[1] ? decode(out_instr_q[63:32]) : '0;
    end

    assign out_valid_o = out_valid_q;
    assign out_pc_o    = out_pc_q;
    assign out_instr_o = out_instr_q;
    assign split_cnt_o = split_cnt_q;
    assign regdst_o    = {out_dec1.regdst, out_dec0.regdst};
    assign jmp_o       = {out_dec1.jmp, out_dec0.jmp};
    assign alusrc1_o   = {out_dec1.alusrc1, out_dec0.alusrc1};
    assign datac_o     = {out_dec1.datac, out_dec0.datac};
    assign regwrite_o  = {out_dec1.regwrite, out_dec0.regwrite};
    assign alusrc_o    = {out_dec1.alusrc, out_dec0.alusrc};
    assign branch_o    = {out_dec1.branch, out_dec0.branch};
    assign bne_o       = {out_dec1.bne, out_dec0.bne};
    assign memread_o   = {out_dec1.memread, out_dec0.memread};
    assign memwrite_o  = {out_dec1.memwrite, out_dec0.memwrite};
    assign memtoreg_o  = {out_dec1.memtoreg, out_dec0.memtoreg};
    assign aluop_o     = {out_dec1.aluop, out_dec0.aluop};

endmodule

// File: tb/tb_dual_issue_ctrl.sv
// Randomized bench: two DUT configurations (MEM_PORTS=1/BR_LANE1=0 and MEM_PORTS=2/BR_LANE1=1)
// share stimulus; each is compared every cycle against a table-driven issue model.
module tb_dual_issue_ctrl;

    localparam int NMN = 24;

    typedef struct packed {
        logic [5:0] op;
        logic [5:0] fn;
        logic [1:0] rdst;
        logic [1:0] jmp;
        logic [1:0] src1;
        logic       datac, rw, asrc, br, bne, mr, mw, m2r;
        logic [5:0] aop;
        logic       use_rs, use_rt;
    } mn_t;

    // One output-stage snapshot: valid bits, instructions, pcs and mnemonic indices
    typedef struct packed {
        logic [1:0]  v;
        logic [31:0] i0, i1, p0, p1;
        logic [4:0]  m0, m1;
    } grp_t;

    logic              clk, rst_ni, flush, in_valid, out_ready;
    logic [31:0]       in_instr0, in_instr1, in_pc;
    logic [1:0]        in_ready;
    logic [1:0][1:0]   out_valid, datac, regwrite, alusrc, branch, bne;
    logic [1:0][1:0]   memread, memwrite, memtoreg;
    logic [1:0][63:0]  out_pc, out_instr;
    logic [1:0][3:0]   regdst, jmp, alusrc1;
    logic [1:0][11:0]  aluop;
    logic [1:0][15:0]  split_cnt;

    mn_t         tbl [NMN];
    grp_t        shown [2];
    grp_t        held [2];
    logic        has_held [2];
    int unsigned scnt [2];
    int          n_checks, n_fail;
    logic [4:0]  m0_cur, m1_cur;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        dual_issue_ctrl #(
            .ALUOP_W  (6),
            .MEM_PORTS(g == 0 ? 1 : 2),
            .BR_LANE1 (g == 0 ? 0 : 1),
            .CNT_W    (16)
        ) u_dut (
            .clk_i      (clk),
            .rst_ni     (rst_ni),
            .flush_i    (flush),
            .in_valid_i (in_valid),
            .in_ready_o (in_ready[g]),
            .in_instr0_i(in_instr0),
            .in_instr1_i(in_instr1),
            .in_pc_i    (in_pc),
            .out_valid_o(out_valid[g]),
            .out_ready_i(out_ready),
            .out_pc_o   (out_pc[g]),
            .out_instr_o(out_instr[g]),
            .regdst_o   (regdst[g]),
            .jmp_o      (jmp[g]),
            .alusrc1_o  (alusrc1[g]),
            .datac_o    (datac[g]),
            .regwrite_o (regwrite[g]),
            .alusrc_o   (alusrc[g]),
            .branch_o   (branch[g]),
            .bne_o      (bne[g]),
            .memread_o  (memread[g]),
            .memwrite_o (memwrite[g]),
            .memtoreg_o (memtoreg[g]),
            .aluop_o    (aluop[g]),
            .split_cnt_o(split_cnt[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // flags: datac rw asrc br bne mr mw m2r; uses: {reads rs, reads rt}
    function automatic mn_t mk(input logic [5:0] op, input logic [5:0] fn, input logic [1:0] rdst,
                               input logic [1:0] jp, input logic [1:0] src1, input logic [7:0] f,
                               input logic [5:0] aop, input logic [1:0] uses);
        mn_t e;
        e.op = op; e.fn = fn; e.rdst = rdst; e.jmp = jp; e.src1 = src1;
        {e.datac, e.rw, e.asrc, e.br, e.bne, e.mr, e.mw, e.m2r} = f;
        e.aop = aop;
        {e.use_rs, e.use_rt} = uses;
        return e;
    endfunction

    function automatic logic [31:0] gen_instr(input logic [4:0] m);
        mn_t        e;
        logic [4:0] rs, rt, rd;
        e  = tbl[m];
        rs = 5'($urandom_range(0, 7));
        rt = 5'($urandom_range(0, 7));
        rd = 5'($urandom_range(0, 7));
        if (e.op == 6'h00) return {e.op, rs, rt, rd, 5'($urandom), e.fn};
        return {e.op, rs, rt, 16'($urandom)};
    endfunction

    function automatic logic [4:0] tb_dest(input mn_t e, input logic [31:0] ins);
        if (!e.rw) return 5'd0;
        if (e.rdst == 2'b01) return ins[15:11];
        if (e.rdst == 2'b10) return 5'd31;
        return ins[20:16];
    endfunction

    function automatic logic must_split(input int k, input logic [31:0] i0, input logic [4:0] m0,
                                        input logic [31:0] i1, input logic [4:0] m1);
        mn_t        a, b;
        logic [4:0] d0, d1;
        logic       raw, waw, mem, ctl;
        a   = tbl[m0];
        b   = tbl[m1];
        d0  = tb_dest(a, i0);
        d1  = tb_dest(b, i1);
        raw = (d0 != 0) && ((b.use_rs && i1[25:21] == d0) || (b.use_rt && i1[20:16] == d0));
        waw = (d0 != 0) && (d1 == d0);
        mem = (k == 0) && (a.mr || a.mw) && (b.mr || b.mw);
        ctl = a.br || (a.jmp != 0) || ((k == 0) && (b.br || (b.jmp != 0)));
        return raw || waw || mem || ctl;
    endfunction

    function automatic logic [39:0] exp_ctrl(input grp_t g);
        mn_t a, b;
        a = g.v[0] ? tbl[g.m0] : '0;
        b = g.v[1] ? tbl[g.m1] : '0;
        return {b.rdst, a.rdst, b.jmp, a.jmp, b.src1, a.src1, b.datac, a.datac, b.rw, a.rw,
                b.asrc, a.asrc, b.br, a.br, b.bne, a.bne, b.mr, a.mr, b.mw, a.mw,
                b.m2r, a.m2r, b.aop, a.aop};
    endfunction

    function automatic logic exp_ready(input int k);
        return rst_ni && !flush && !has_held[k] && (out_ready || shown[k].v == 2'b00);
    endfunction

    task automatic model_reset(input int k);
        shown[k]    = '0;
        held[k]     = '0;
        has_held[k] = 1'b0;
        scnt[k]     = 0;
    endtask

    task automatic model_step(input int k);
        logic rdy, adv;
        rdy = exp_ready(k);
        adv = out_ready || shown[k].v == 2'b00;
        if (flush) begin
            shown[k]    = '0;
            has_held[k] = 1'b0;
        end else if (adv) begin
            if (has_held[k]) begin
                shown[k]    = held[k];
                has_held[k] = 1'b0;
            end else if (in_valid && rdy) begin
                shown[k] = '{v: 2'b11, i0: in_instr0, i1: in_instr1, p0: in_pc,
                             p1: in_pc + 32'd4, m0: m0_cur, m1: m1_cur};
                if (must_split(k, in_instr0, m0_cur, in_instr1, m1_cur)) begin
                    held[k]     = '{v: 2'b01, i0: in_instr1, i1: 32'd0, p0: in_pc + 32'd4,
                                    p1: 32'd0, m0: m1_cur, m1: 5'd0};
                    has_held[k] = 1'b1;
                    shown[k].v  = 2'b01;
                    shown[k].i1 = 32'd0;
                    shown[k].p1 = 32'd0;
                    shown[k].m1 = 5'd0;
                    if (scnt[k] < 32'hFFFF) scnt[k]++;
                end
            end else begin
                shown[k] = '0;
            end
        end
    endtask

    task automatic check_outputs(input int k);
        check_eq($sformatf("valid[%0d]", k), 64'(out_valid[k]), 64'(shown[k].v));
        check_eq($sformatf("in_ready[%0d]", k), 64'(in_ready[k]), 64'(exp_ready(k)));
        check_eq($sformatf("ctrl[%0d]", k),
                 64'({regdst[k], jmp[k], alusrc1[k], datac[k], regwrite[k], alusrc[k],
                      branch[k], bne[k], memread[k], memwrite[k], memtoreg[k], aluop[k]}),
                 64'(exp_ctrl(shown[k])));
        check_eq($sformatf("pc[%0d]", k), out_pc[k], {shown[k].p1, shown[k].p0});
        check_eq($sformatf("instr[%0d]", k), out_instr[k], {shown[k].i1, shown[k].i0});
        check_eq($sformatf("split_cnt[%0d]", k), 64'(split_cnt[k]), 64'(scnt[k]));
    endtask

    initial begin
        tbl[0]  = mk(6'h00, 6'h20, 2'b01, 2'b00, 2'b00, 8'b0100_0000, 6'h20, 2'b11); // add
        tbl[1]  = mk(6'h00, 6'h25, 2'b01, 2'b00, 2'b00, 8'b0100_0000, 6'h25, 2'b11); // or
        tbl[2]  = mk(6'h00, 6'h22, 2'b01, 2'b00, 2'b00, 8'b0100_0000, 6'h22, 2'b11); // sub
        tbl[3]  = mk(6'h00, 6'h24, 2'b01, 2'b00, 2'b00, 8'b0100_0000, 6'h24, 2'b11); // and
        tbl[4]  = mk(6'h00, 6'h2A, 2'b01, 2'b00, 2'b00, 8'b0100_0000, 6'h2A, 2'b11); // slt
        tbl[5]  = mk(6'h00, 6'h00, 2'b01, 2'b00, 2'b01, 8'b0100_0000, 6'h04, 2'b01); // sll
        tbl[6]  = mk(6'h00, 6'h02, 2'b01, 2'b00, 2'b01, 8'b0100_0000, 6'h06, 2'b01); // srl
        tbl[7]  = mk(6'h00, 6'h08, 2'b00, 2'b10, 2'b00, 8'b0000_0000, 6'h00, 2'b11); // jr
        tbl[8]  = mk(6'h00, 6'h09, 2'b10, 2'b10, 2'b00, 8'b1100_0000, 6'h00, 2'b11); // jalr
        tbl[9]  = mk(6'h08, 6'h00, 2'b00, 2'b00, 2'b00, 8'b0110_0000, 6'h20, 2'b10); // addi
        tbl[10] = mk(6'h09, 6'h00, 2'b00, 2'b00, 2'b00, 8'b0110_0000, 6'h21, 2'b10); // addiu
        tbl[11] = mk(6'h0A, 6'h00, 2'b00, 2'b00, 2'b00, 8'b0110_0000, 6'h2A, 2'b10); // slti
        tbl[12] = mk(6'h0B, 6'h00, 2'b00, 2'b00, 2'b00, 8'b0110_0000, 6'h2B, 2'b10); // sltiu
        tbl[13] = mk(6'h0C, 6'h00, 2'b00, 2'b00, 2'b00, 8'b0110_0000, 6'h24, 2'b10); // andi
        tbl[14] = mk(6'h0D, 6'h00, 2'b00, 2'b00, 2'b00, 8'b0110_0000, 6'h25, 2'b10); // ori
        tbl[15] = mk(6'h0E, 6'h00, 2'b00, 2'b00, 2'b00, 8'b0110_0000, 6'h26, 2'b10); // xori
        tbl[16] = mk(6'h0F, 6'h00, 2'b00, 2'b00, 2'b10, 8'b0110_0000, 6'h04, 2'b00); // lui
        tbl[17] = mk(6'h23, 6'h00, 2'b00, 2'b00, 2'b00, 8'b0110_0101, 6'h20, 2'b10); // lw
        tbl[18] = mk(6'h2B, 6'h00, 2'b00, 2'b00, 2'b00, 8'b0010_0010, 6'h20, 2'b11); // sw
        tbl[19] = mk(6'h04, 6'h00, 2'b00, 2'b00, 2'b00, 8'b0001_0000, 6'h22, 2'b11); // beq
        tbl[20] = mk(6'h05, 6'h00, 2'b00, 2'b00, 2'b00, 8'b0001_1000, 6'h22, 2'b11); // bne
        tbl[21] = mk(6'h02, 6'h00, 2'b00, 2'b01, 2'b00, 8'b0000_0000, 6'h00, 2'b00); // j
        tbl[22] = mk(6'h03, 6'h00, 2'b10, 2'b01, 2'b00, 8'b1100_0000, 6'h00, 2'b00); // jal
        tbl[23] = mk(6'h3F, 6'h00, 2'b00, 2'b00, 2'b00, 8'b0000_0000, 6'h00, 2'b10); // unknown
        n_checks  = 0;
        n_fail    = 0;
        rst_ni    = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_instr0 = 32'd0;
        in_instr1 = 32'd0;
        in_pc     = 32'd0;
        m0_cur    = 5'd0;
        m1_cur    = 5'd0;
        for (int k = 0; k < 2; k++) model_reset(k);
        repeat (3) @(negedge clk);
        #1;
        for (int k = 0; k < 2; k++) check_outputs(k);

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            rst_ni    = (cyc % 700 != 699);
            flush     = ($urandom_range(0, 19) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            m0_cur    = 5'($urandom_range(0, NMN - 1));
            m1_cur    = 5'($urandom_range(0, NMN - 1));
            in_instr0 = gen_instr(m0_cur);
            in_instr1 = gen_instr(m1_cur);
            in_pc     = $urandom & 32'hFFFF_FFFC;
            if (!rst_ni) begin
                for (int k = 0; k < 2; k++) model_reset(k);
            end
            #1;
            for (int k = 0; k < 2; k++) check_outputs(k);
            if (rst_ni) begin
                for (int k = 0; k < 2; k++) model_step(k);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
